axil_mem_responder: RTL and testbench

Memory-side responder for the fetch/load-store bus used by the CPU front end. It accepts AXI-lite-style read requests (ar/r channels, as issued by the fetch unit) and write requests (aw/w/b channels), and serves them from an internal word-addressed array. Response latency is programmable, so the pipeline's valid/ready behaviour can be exercised with the memory inside the simulated core. It handles one outstanding transaction at a time.

---
 rtl/axil_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_axil_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_responder.sv
// AXI-lite style memory responder: one outstanding read or write, served from a
// word-addressed array with programmable response latency.
module axil_mem_responder #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned            RD_LAT     = 1,
  parameter int unsigned            WR_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = DEPTH_LOG2;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_RESP = 3'd2;
  localparam logic [2:0] S_WR_WAIT = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [2:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic                  hit_q,    hit_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [STRB_W-1:0]     wstrb_q,  wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [1:0]            rresp_q,  rresp_d;
  logic [1:0]            bresp_q,  bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  bvalid_q, bvalid_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we_c;

  logic [ADDR_WIDTH-1:0] ar_off_c, aw_off_c;
  logic                  ar_hit_c, aw_hit_c;
  logic                  aw_go_c;
  logic                  unused_off_c;

  // Address decode: offset from base, low two bits are a byte lane and ignored
  assign ar_off_c = araddr - BASE_ADDR;
  assign aw_off_c = awaddr - BASE_ADDR;
  assign ar_hit_c = (araddr >= BASE_ADDR) && ((ar_off_c >> (IDX_W + 2)) == '0);
  assign aw_hit_c = (awaddr >= BASE_ADDR) && ((aw_off_c >> (IDX_W + 2)) == '0);
  assign unused_off_c = ^{ar_off_c[1:0], aw_off_c[1:0]};

  // Reads win arbitration; AW and W are only ever taken together
  assign aw_go_c = (state_q == S_IDLE) && !arvalid && awvalid && wvalid;
  assign arready = (state_q == S_IDLE);
  assign awready = aw_go_c;
  assign wready  = aw_go_c;

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    mem_we_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          idx_d   = ar_off_c[IDX_W+1:2];
          hit_d   = ar_hit_c;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_RD_WAIT;
        end else if (aw_go_c) begin
          idx_d   = aw_off_c[IDX_W+1:2];
          hit_d   = aw_hit_c;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_W'(WR_LAT);
          state_d = S_WR_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = hit_q ? mem[idx_q] : '0;
          rresp_d  = hit_q ? RESP_OKAY : RESP_DECERR;
          rvalid_d = 1'b1;
          state_d  = S_RD_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_WR_WAIT: begin
        if (cnt_q == '0) begin
          // Array commits in the same edge bvalid rises; reset drops the write
          mem_we_c = hit_q && !rst;
          bresp_d  = hit_q ? RESP_OKAY : RESP_DECERR;
          bvalid_d = 1'b1;
          state_d  = S_WR_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Byte-masked array write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_responder.sv
// Directed bench for axil_mem_responder: three instances with latencies 1/1, 0/0 and 3/3.
module tb_axil_mem_responder;

  logic        clk;
  logic [2:0]  rst, arvalid, arready, rvalid, rready;
  logic [2:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr [3];
  logic [31:0] rdata  [3];
  logic [31:0] awaddr [3];
  logic [31:0] wdata  [3];
  logic [1:0]  rresp  [3];
  logic [1:0]  bresp  [3];
  logic [3:0]  wstrb  [3];

  int n_chk  = 0;
  int n_pass = 0;
  int busy_hi;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
    axil_mem_responder #(.RD_LAT(LAT), .WR_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst[g]),
      .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
      .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
      .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
      .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the ar handshake edge until rvalid is seen
  task automatic do_read(input int d, input logic [31:0] a, output int lat,
                         output logic [31:0] data, output logic [1:0] resp);
    int k;
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b1;
    #1;
    k = 0;
    while (!arready[d] && k < 30) begin step(); k++; end
    step();
    arvalid[d] = 1'b0;
    lat = 0; busy_hi = 0;
    while (!rvalid[d] && lat < 30) begin
      if (arready[d]) busy_hi++;
      step(); lat++;
    end
    if (arready[d]) busy_hi++;
    data = rdata[d]; resp = rresp[d];
    step();
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dt,
                          input logic [3:0] st, output int lat, output logic [1:0] resp);
    int k;
    awaddr[d] = a; wdata[d] = dt; wstrb[d] = st;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
    #1;
    k = 0;
    while (!awready[d] && k < 30) begin step(); k++; end
    step();
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    lat = 0;
    while (!bvalid[d] && lat < 30) begin step(); lat++; end
    resp = bresp[d];
    step();
  endtask

  initial begin
    int          lat, cnt;
    logic [31:0] data;
    logic [1:0]  resp;

    rst = 3'b111; arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    step(); step();
    chk("rst_rvalid",  32'(rvalid[0]),  32'd0);
    chk("rst_bvalid",  32'(bvalid[0]),  32'd0);
    chk("rst_rdata",   rdata[0],        32'd0);
    chk("rst_rresp",   32'(rresp[0]),   32'd0);
    chk("rst_bresp",   32'(bresp[0]),   32'd0);
    chk("rst_arready", 32'(arready[0]), 32'd1);
    chk("rst_awready", 32'(awready[0]), 32'd0);
    rst = 3'b000;
    step();

    // Read after write, default latency
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, resp);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_bresp", 32'(resp), 32'd0);
    do_read(0, 32'h8000_0010, lat, data, resp);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", data, 32'hDEAD_BEEF);
    chk("rd_rresp", 32'(resp), 32'd0);
    chk("rd_arready_busy", 32'(busy_hi), 32'd0);
    do_read(0, 32'h8000_0013, lat, data, resp);
    chk("rd_lowbits_ignored", data, 32'hDEAD_BEEF);

    // Partial strobe
    do_write(0, 32'h8000_0020, 32'h1122_3344, 4'hF, lat, resp);
    do_write(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, lat, resp);
    do_read(0, 32'h8000_0020, lat, data, resp);
    chk("strobe_data", data, 32'h11BB_33DD);

    // Range boundaries: last word is in range, one past the end and below base are not
    do_write(0, 32'h8000_0FFC, 32'h0F0F_1234, 4'hF, lat, resp);
    chk("last_word_bresp", 32'(resp), 32'd0);
    do_read(0, 32'h8000_0FFC, lat, data, resp);
    chk("last_word_data", data, 32'h0F0F_1234);
    do_write(0, 32'h8000_1000, 32'h5555_5555, 4'hF, lat, resp);
    chk("past_end_bresp", 32'(resp), 32'd3);
    do_write(0, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, lat, resp);
    chk("below_base_bresp", 32'(resp), 32'd3);
    do_read(0, 32'h8000_1000, lat, data, resp);
    chk("past_end_rresp", 32'(resp), 32'd3);
    chk("past_end_rdata", data, 32'd0);

    // Backpressure: rready low for 5 response cycles
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b0;
    #1;
    step();
    arvalid[0] = 1'b0;
    cnt = 0;
    while (!rvalid[0] && cnt < 30) begin step(); cnt++; end
    chk("bp_lat", 32'(cnt), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 32'(rvalid[0]), 32'd1);
      chk("bp_rdata", rdata[0], 32'hDEAD_BEEF);
      step();
    end
    rready[0] = 1'b1;
    chk("bp_hold_rvalid", 32'(rvalid[0]), 32'd1);
    step();
    chk("bp_done_rvalid", 32'(rvalid[0]), 32'd0);
    chk("bp_idle_arready", 32'(arready[0]), 32'd1);

    // Simultaneous read and write requests: read wins
    araddr[0] = 32'h7000_0000; arvalid[0] = 1'b1; rready[0] = 1'b1;
    awaddr[0] = 32'h8000_0030; wdata[0] = 32'h1234_5678; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    #1;
    chk("col_arready", 32'(arready[0]), 32'd1);
    chk("col_awready", 32'(awready[0]), 32'd0);
    chk("col_wready",  32'(wready[0]),  32'd0);
    step();
    arvalid[0] = 1'b0;
    #1;
    chk("col_aw_blocked", 32'(awready[0]), 32'd0);
    cnt = 0;
    while (!rvalid[0] && cnt < 30) begin step(); cnt++; end
    chk("col_rd_lat", 32'(cnt), 32'd2);
    chk("col_rresp", 32'(rresp[0]), 32'd3);
    chk("col_rdata", rdata[0], 32'd0);
    step();
    chk("col_aw_accept", 32'(awready[0]), 32'd1);
    step();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    cnt = 0;
    while (!bvalid[0] && cnt < 30) begin step(); cnt++; end
    chk("col_wr_lat", 32'(cnt), 32'd2);
    chk("col_bresp", 32'(bresp[0]), 32'd0);
    step();
    do_read(0, 32'h8000_0030, lat, data, resp);
    chk("col_wr_data", data, 32'h1234_5678);

    // Latency sweep: zero-latency instance
    do_write(1, 32'h8000_0004, 32'hA5A5_0001, 4'hF, lat, resp);
    chk("lat0_wr_lat", 32'(lat), 32'd1);
    do_read(1, 32'h8000_0004, lat, data, resp);
    chk("lat0_rd_lat", 32'(lat), 32'd1);
    chk("lat0_rd_data", data, 32'hA5A5_0001);
    chk("lat0_arready_busy", 32'(busy_hi), 32'd0);

    // Latency sweep: three-cycle instance
    do_write(2, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, lat, resp);
    chk("lat3_wr_lat", 32'(lat), 32'd4);
    do_read(2, 32'h8000_0040, lat, data, resp);
    chk("lat3_rd_lat", 32'(lat), 32'd4);
    chk("lat3_rd_data", data, 32'hCAFE_F00D);
    chk("lat3_arready_busy", 32'(busy_hi), 32'd0);

    // Reset during WR_WAIT drops the pending write
    awaddr[2] = 32'h8000_0040; wdata[2] = 32'h0BAD_BEEF; wstrb[2] = 4'hF;
    awvalid[2] = 1'b1; wvalid[2] = 1'b1; bready[2] = 1'b1;
    #1;
    chk("rstw_awready", 32'(awready[2]), 32'd1);
    step();
    awvalid[2] = 1'b0; wvalid[2] = 1'b0; rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    #1;
    chk("rstw_arready", 32'(arready[2]), 32'd1);
    chk("rstw_bvalid", 32'(bvalid[2]), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bvalid[2]) cnt++;
      step();
    end
    chk("rstw_no_bvalid", 32'(cnt), 32'd0);
    do_read(2, 32'h8000_0040, lat, data, resp);
    chk("rstw_old_data", data, 32'hCAFE_F00D);
    chk("rstw_rresp", 32'(resp), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
